// File: rtl/hilo_div_if.sv
`default_nettype none
// ============================================================================
// hilo_div_if : EXE-stage command bundle and HI/LO result bundle
// Rev 1.0
// ============================================================================
interface hilo_div_if #(
    parameter int DATA_W = 32
);
    logic                  op_valid;
    logic [1:0]            mult_op;
    logic [1:0]            div_op;
    logic [1:0]            mthl_op;
    logic [1:0]            mfhl_op;
    logic [DATA_W-1:0]     src_a;
    logic [DATA_W-1:0]     src_b;
    logic [2*DATA_W-1:0]   mult_result;
    logic                  cancel;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic                  busy;
    logic                  stall;
    logic                  div_complete;

    modport master (
        output op_valid, mult_op, div_op, mthl_op, mfhl_op,
        output src_a, src_b, mult_result, cancel,
        input  hi, lo, busy, stall, div_complete
    );

    modport slave (
        input  op_valid, mult_op, div_op, mthl_op, mfhl_op,
        input  src_a, src_b, mult_result, cancel,
        output hi, lo, busy, stall, div_complete
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// hilo_div_ctrl : HI/LO owner with radix-2 restoring divide sequencer
// Rev 1.0
// ============================================================================
module hilo_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    hilo_div_if.slave   bus
);
    localparam int c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DIV_RUN = 2'd1;
    localparam logic [1:0] c_DIV_FIX = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic [DATA_W-1:0]  r_quo;
    logic [DATA_W-1:0]  r_rem;
    logic [DATA_W-1:0]  r_dvs;
    logic [DATA_W-1:0]  r_raw_a;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dvs_zero;

    logic               w_busy;
    logic               w_stall;
    logic               w_div_complete;
    logic               w_accept;
    logic               w_is_div;
    logic               w_is_mult;
    logic               w_is_mthl;
    logic               w_any_op;
    logic               w_last;
    logic               w_signed;
    logic [DATA_W-1:0]  w_a_mag;
    logic [DATA_W-1:0]  w_b_mag;
    logic [DATA_W:0]    w_rem_sh;
    logic [DATA_W-1:0]  w_rem_sub;
    logic               w_ge;
    logic [DATA_W-1:0]  w_q_fix;
    logic [DATA_W-1:0]  w_r_fix;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign w_is_div  = |bus.div_op;
    assign w_is_mult = |bus.mult_op;
    assign w_is_mthl = |bus.mthl_op;
    assign w_any_op  = w_is_div | w_is_mult | w_is_mthl | (|bus.mfhl_op);
    assign w_accept  = bus.op_valid & ~w_busy & ~bus.cancel;
    assign w_last    = (r_cnt == c_CNT_LAST);

    // Signed-ness follows the DIV bit; DIVU alone latches raw operands
    assign w_signed  = bus.div_op[1];
    assign w_a_mag   = (w_signed & bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
    assign w_b_mag   = (w_signed & bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

    // One restoring step: the shifted partial remainder is DATA_W+1 bits wide,
    // but whenever it reaches the divisor the difference fits in DATA_W bits.
    assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_dvs;

    assign w_q_fix   = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix   = r_r_neg ? -r_rem : r_rem;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && w_is_div) begin
                    w_state_nxt = c_DIV_RUN;
                end
            end
            c_DIV_RUN: begin
                if (bus.cancel) begin
                    w_state_nxt = c_IDLE;
                end else if (w_last) begin
                    w_state_nxt = c_DIV_FIX;
                end
            end
            c_DIV_FIX: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy         = (r_state != c_IDLE);
        w_div_complete = (r_state == c_DIV_FIX);
        // Stall releases in DIV_FIX so ID/EXE reloads alongside div_complete
        w_stall        = (r_state == c_DIV_RUN) |
                         (w_busy & bus.op_valid & w_any_op & (r_state != c_DIV_FIX));
    end

    // ------------------------------------------------------------------
    // Datapath: divider registers and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_raw_a    <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dvs_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_is_div) begin
                            r_quo      <= w_a_mag;
                            r_dvs      <= w_b_mag;
                            r_raw_a    <= bus.src_a;
                            r_rem      <= '0;
                            r_cnt      <= '0;
                            r_q_neg    <= w_signed & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                            r_r_neg    <= w_signed & bus.src_a[DATA_W-1];
                            r_dvs_zero <= (bus.src_b == '0);
                        end else if (w_is_mult) begin
                            {r_hi, r_lo} <= bus.mult_result;
                        end else if (w_is_mthl) begin
                            if (bus.mthl_op[1]) begin
                                r_hi <= bus.src_a;
                            end
                            if (bus.mthl_op[0]) begin
                                r_lo <= bus.src_a;
                            end
                        end
                    end
                end
                c_DIV_RUN: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], w_ge};
                    r_cnt <= (w_last || bus.cancel) ? '0 : r_cnt + c_CNT_ONE;
                end
                c_DIV_FIX: begin
                    if (r_dvs_zero) begin
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.busy         = w_busy;
    assign bus.stall        = w_stall;
    assign bus.div_complete = w_div_complete;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// Bench for hilo_div_ctrl: directed vector table, multi-cycle corner
// sequences and random commands checked against an arithmetic model.
module tb_hilo_div_ctrl;
    localparam int DW = 32;

    typedef enum int {
        K_DIVU, K_DIV, K_MULTU, K_MULT, K_MTHI, K_MTLO, K_DIVMULT, K_MULTMT
    } kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] mres;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    hilo_div_if #(.DATA_W(DW)) bus ();

    hilo_div_ctrl #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.op_valid    = 1'b0;
        bus.mult_op     = 2'b00;
        bus.div_op      = 2'b00;
        bus.mthl_op     = 2'b00;
        bus.mfhl_op     = 2'b00;
        bus.cancel      = 1'b0;
    endtask

    function automatic bit is_div(input kind_t k);
        return (k == K_DIVU) || (k == K_DIV) || (k == K_DIVMULT);
    endfunction

    task automatic drive_op(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] m);
        idle_inputs();
        bus.op_valid    = 1'b1;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.mult_result = m;
        case (k)
            K_DIVU:    bus.div_op  = 2'b01;
            K_DIV:     bus.div_op  = 2'b10;
            K_MULTU:   bus.mult_op = 2'b01;
            K_MULT:    bus.mult_op = 2'b10;
            K_MTHI:    bus.mthl_op = 2'b10;
            K_MTLO:    bus.mthl_op = 2'b01;
            K_DIVMULT: begin bus.div_op = 2'b01; bus.mult_op = 2'b10; end
            K_MULTMT:  begin bus.mult_op = 2'b01; bus.mthl_op = 2'b11; end
            default:   bus.op_valid = 1'b0;
        endcase
    endtask

    // Architectural result of one command, from MIPS HI/LO rules
    function automatic void ref_exec(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                                     input logic [63:0] m, input logic [31:0] hi_in,
                                     input logic [31:0] lo_in,
                                     output logic [31:0] hi_o, output logic [31:0] lo_o);
        longint sa, sb, q, r;
        hi_o = hi_in;
        lo_o = lo_in;
        case (k)
            K_MULT, K_MULTU, K_MULTMT: {hi_o, lo_o} = m;
            K_MTHI: hi_o = a;
            K_MTLO: lo_o = a;
            K_DIVU, K_DIVMULT: begin
                if (b == 0) begin hi_o = a; lo_o = '1; end
                else begin hi_o = a % b; lo_o = a / b; end
            end
            K_DIV: begin
                if (b == 0) begin
                    hi_o = a; lo_o = '1;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    lo_o = 32'(q);
                    hi_o = 32'(r);
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one command in cycle T and follow it to completion
    task automatic run_op(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] m, input logic [31:0] eh, input logic [31:0] el,
                          input string name);
        drive_op(k, a, b, m);
        #1;
        check({name, " accept ctrl"}, {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'd0);
        step();
        idle_inputs();
        if (is_div(k)) begin
            for (int c = 1; c <= DW + 1; c++) begin
                #1;
                check($sformatf("%s ctrl T+%0d", name, c),
                      {61'd0, bus.busy, bus.stall, bus.div_complete},
                      {61'd0, 1'b1, (c <= DW), (c == DW + 1)});
                if (c == DW + 1)
                    check({name, " hilo before commit"}, {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
                step();
            end
        end
        check({name, " hilo"}, {bus.hi, bus.lo}, {eh, el});
        check({name, " idle after"}, {63'd0, bus.busy}, 64'd0);
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    vec_t tbl[12];

    initial begin
        logic [31:0] eh, el, a, b;
        logic [63:0] m;
        kind_t       k;

        tbl[0]  = '{K_DIVU,    32'd100,        32'd7,          64'd0, 32'd2,          32'd14};
        tbl[1]  = '{K_DIV,     32'hFFFF_FFF9,  32'd2,          64'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
        tbl[2]  = '{K_DIV,     32'd7,          32'hFFFF_FFFE,  64'd0, 32'd1,          32'hFFFF_FFFD};
        tbl[3]  = '{K_DIVU,    32'h0000_1234,  32'd0,          64'd0, 32'h0000_1234,  32'hFFFF_FFFF};
        tbl[4]  = '{K_DIV,     32'h8000_0000,  32'hFFFF_FFFF,  64'd0, 32'd0,          32'h8000_0000};
        tbl[5]  = '{K_MULT,    32'd0, 32'd0,   64'h0000_0001_FFFF_FFFE, 32'd1,        32'hFFFF_FFFE};
        tbl[6]  = '{K_MTLO,    32'h0000_00A5,  32'd0,          64'd0, 32'd1,          32'h0000_00A5};
        tbl[7]  = '{K_MTHI,    32'hDEAD_BEEF,  32'd0,          64'd0, 32'hDEAD_BEEF,  32'h0000_00A5};
        tbl[8]  = '{K_DIV,     32'hFFFF_FFF9,  32'd0,          64'd0, 32'hFFFF_FFF9,  32'hFFFF_FFFF};
        tbl[9]  = '{K_DIV,     32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'd0, 32'hFFFF_FFFE,  32'd14};
        tbl[10] = '{K_DIVMULT, 32'd20,         32'd6,  64'h0000_0009_0000_0009, 32'd2, 32'd3};
        tbl[11] = '{K_MULTMT,  32'h77, 32'd0,  64'h0000_0005_0000_0006, 32'd5,  32'd6};

        idle_inputs();
        bus.src_a = '0; bus.src_b = '0; bus.mult_result = '0;
        rst = 1'b1;
        step();
        step();
        check("reset outputs", {bus.hi, bus.lo}, 64'd0);
        check("reset ctrl", {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'd0);
        rst = 1'b0;
        step();

        foreach (tbl[i])
            run_op(tbl[i].kind, tbl[i].a, tbl[i].b, tbl[i].mres,
                   tbl[i].exp_hi, tbl[i].exp_lo, $sformatf("vec%0d", i));

        // A command held in EXE across a divide: MFHI waits in DIV_RUN,
        // a MULT presented in DIV_FIX must wait for IDLE.
        drive_op(K_DIVU, 32'd1000, 32'd10, 64'd0);
        step();
        idle_inputs();
        bus.op_valid = 1'b1;
        bus.mfhl_op  = 2'b10;
        for (int c = 1; c <= DW; c++) begin
            #1;
            check($sformatf("hold stall T+%0d", c), {63'd0, bus.stall}, 64'd1);
            step();
        end
        bus.mfhl_op     = 2'b00;
        bus.mult_op     = 2'b01;
        bus.mult_result = 64'h0000_00AB_0000_00CD;
        #1;
        check("hold fix ctrl", {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'b101);
        step();
        check("hold div commit", {bus.hi, bus.lo}, {32'd0, 32'd100});
        check("hold idle ctrl", {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'd0);
        step();
        idle_inputs();
        check("hold mult after", {bus.hi, bus.lo}, 64'h0000_00AB_0000_00CD);
        mdl_hi = 32'hAB;
        mdl_lo = 32'hCD;

        // Cancel at T=10 of a divide
        drive_op(K_DIVU, 32'h0000_FFFF, 32'd3, 64'd0);
        step();
        idle_inputs();
        for (int c = 1; c < 10; c++) step();
        bus.cancel = 1'b1;
        #1;
        check("cancel T10 ctrl", {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'b110);
        step();
        bus.cancel = 1'b0;
        for (int c = 11; c <= 14; c++) begin
            #1;
            check($sformatf("cancel ctrl T%0d", c),
                  {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'd0);
            step();
        end
        check("cancel hilo", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});

        // MULT presented together with cancel in IDLE is dropped
        drive_op(K_MULT, 32'd0, 32'd0, 64'h1234_5678_9ABC_DEF0);
        bus.cancel = 1'b1;
        step();
        idle_inputs();
        step();
        check("cancel mult hilo", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});

        // Asynchronous reset in the middle of a divide
        run_op(K_MTHI, 32'h1111, 32'd0, 64'd0, 32'h1111, mdl_lo, "pre-rst mthi");
        run_op(K_MTLO, 32'h2222, 32'd0, 64'd0, 32'h1111, 32'h2222, "pre-rst mtlo");
        drive_op(K_DIVU, 32'd77, 32'd5, 64'd0);
        step();
        idle_inputs();
        for (int c = 1; c < 20; c++) step();
        #2;
        rst = 1'b1;
        #1;
        check("async rst hilo", {bus.hi, bus.lo}, 64'd0);
        check("async rst ctrl", {61'd0, bus.busy, bus.stall, bus.div_complete}, 64'd0);
        step();
        rst = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        step();
        run_op(K_DIVU, 32'd9, 32'd3, 64'd0, 32'd0, 32'd3, "post-rst divu");

        // Random commands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            k = kind_t'($urandom_range(0, 5));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 9);
                2:       b = 32'hFFFF_FFFF;
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:       b = $urandom >> $urandom_range(1, 30);
                default: b = $urandom;
            endcase
            m = {$urandom, $urandom};
            ref_exec(k, a, b, m, mdl_hi, mdl_lo, eh, el);
            run_op(k, a, b, m, eh, el, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
